// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. A single full-adder cell with a registered
//   carry produces one sum bit per clock, LSB first. An add takes WIDTH SHIFT
//   cycles followed by a one-cycle DONE pulse. Area is traded for throughput.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request: sample a, b, cin and begin an add (IDLE/DONE)
//   a      in   WIDTH  operand A, sampled only on an accepted start
//   b      in   WIDTH  operand B, sampled only on an accepted start
//   cin    in   1      carry-in, sampled only on an accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse: sum/cout valid
//   sum    out  WIDTH  result, held from done until the next accepted start
//   cout   out  1      carry-out, held as for sum
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The one adder cell, fed from the LSBs of the operand shift registers.
  logic bit_s;
  logic bit_c;

  assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign bit_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      // IDLE and DONE both accept a new request; DONE allows back-to-back adds.
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      // Sum bits enter at the MSB and shift down, so after WIDTH cycles the
      // first (LSB) result bit sits in sum[0]. start is ignored here.
      SHIFT: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = bit_c;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status decoded straight from state so an asynchronous reset clears it at once.
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Expected {cout,sum}
//   values are computed as a+b+cin when a start is driven, queued, and
//   compared when done is seen. Directed scenarios are followed by a block
//   of randomised adds.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; all driving and sampling happens there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start and queue the expected result.
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    exp_q.push_back((W+1)'(av) + (W+1)'(bv) + (W+1)'(cv));
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Wait (bounded) for done, then pop and compare. Reports cycles waited and busy cycles seen.
  task automatic wait_done(input string tag, output int n, output int busy_cnt);
    logic [W:0] e;
    n        = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && n < 40) begin
      step();
      n++;
      if (busy) busy_cnt++;
    end
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (done) chk(tag, 32'({cout, sum}), 32'(e));
  endtask

  initial begin
    int n;
    int bc;
    int dcnt;
    logic [W-1:0] hold;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // 1: zero + zero, latency and one-cycle done pulse, sum held afterwards
    do_start(8'h00, 8'h00, 1'b0);
    wait_done("t1_res", n, bc);
    chk("t1_latency", 32'(n), 32'd8);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // 2: 3C + 0F, busy high exactly WIDTH cycles, result held in IDLE
    do_start(8'h3C, 8'h0F, 1'b0);
    wait_done("t2_res", n, bc);
    chk("t2_busy_cycles", 32'(bc), 32'd8);
    hold = sum;
    step();
    step();
    step();
    chk("t2_sum_hold", 32'(sum), 32'(hold));
    chk("t2_sum_val", 32'(sum), 32'h4B);

    // 3: full carry ripple
    do_start(8'hFF, 8'h01, 1'b0);
    wait_done("t3_res", n, bc);
    chk("t3_cout", 32'(cout), 32'd1);

    // 4: A5 + 5A + 1, then back-to-back start in the DONE cycle
    do_start(8'hA5, 8'h5A, 1'b1);
    wait_done("t4a_res", n, bc);
    do_start(8'h01, 8'h01, 1'b0);
    chk("t4_b2b_busy", 32'(busy), 32'd1);
    wait_done("t4b_res", n, bc);
    chk("t4b_latency", 32'(n), 32'd8);

    // 5: start while busy is ignored
    do_start(8'h10, 8'h20, 1'b0);
    step();
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    step();
    start = 1'b0;
    wait_done("t5_res", n, bc);
    chk("t5_latency", 32'(n), 32'd6);
    step();
    chk("t5_no_extra_done", 32'(done), 32'd0);

    // 6: reset during the 4th SHIFT cycle aborts the add
    do_start(8'h77, 8'h99, 1'b1);
    step();
    step();
    step();
    chk("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_sum",  32'(sum),  32'd0);
    chk("t6_rst_cout", 32'(cout), 32'd0);
    void'(exp_q.pop_front());
    step();
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) dcnt++;
    end
    chk("t6_no_done", 32'(dcnt), 32'd0);
    do_start(8'hC3, 8'h4E, 1'b1);
    wait_done("t6_after", n, bc);

    // Randomised adds, some issued back-to-back from the DONE cycle
    for (int i = 0; i < 1000; i++) begin
      do_start(W'($urandom), W'($urandom), 1'($urandom));
      wait_done("rand", n, bc);
      if ($urandom_range(0, 3) == 0) step();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
